// File: rtl/dmem_mmio_pkg.sv
// Shared types and constants for the data-memory / MMIO subsystem.
// The timer block is built only when DMEM_MMIO_TIMER_EN is defined.
package dmem_mmio_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OFS_W  = 4;

  localparam logic [OFS_W-1:0] OFS_GPIO_OUT    = 4'd0;
  localparam logic [OFS_W-1:0] OFS_GPIO_IN     = 4'd1;
  localparam logic [OFS_W-1:0] OFS_TIMER_COUNT = 4'd2;
  localparam logic [OFS_W-1:0] OFS_TIMER_CMP   = 4'd3;
  localparam logic [OFS_W-1:0] OFS_TIMER_CTRL  = 4'd4;
  localparam logic [OFS_W-1:0] OFS_BUS_ERR     = 4'd5;

  localparam int unsigned CTRL_ENABLE_BIT      = 0;
  localparam int unsigned CTRL_AUTO_RELOAD_BIT = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT      = 2;
  localparam int unsigned CTRL_PENDING_BIT     = 3;

  // Field order puts enable at bit 0 so the struct maps straight onto the register.
  typedef struct packed {
    logic pending;
    logic irq_en;
    logic auto_reload;
    logic enable;
  } timer_ctrl_t;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_e;

endpackage

// File: rtl/mmio_timer.sv
// 32-bit free-running timer with compare match, auto-reload and W1C pending flag.
// Present only when DMEM_MMIO_TIMER_EN is defined.
`ifdef DMEM_MMIO_TIMER_EN
module mmio_timer
  import dmem_mmio_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_count,
  input  logic              wr_cmp,
  input  logic              wr_ctrl,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] count,
  output logic [DATA_W-1:0] cmp,
  output timer_ctrl_t       ctrl,
  output logic              irq_c
);

  logic [DATA_W-1:0] count_d;
  logic [DATA_W-1:0] cmp_d;
  timer_ctrl_t       ctrl_d;
  logic              match;

  // Match uses pre-update count/ctrl; a software COUNT write overrides reload and increment.
  always_comb begin
    match   = ctrl.enable && (count == cmp);
    count_d = count;
    cmp_d   = cmp;
    ctrl_d  = ctrl;
    if (wr_count) begin
      count_d = wdata;
    end else if (match && ctrl.auto_reload) begin
      count_d = '0;
    end else if (ctrl.enable) begin
      count_d = count + DATA_W'(1);
    end
    if (wr_cmp) begin
      cmp_d = wdata;
    end
    if (wr_ctrl) begin
      ctrl_d.enable      = wdata[CTRL_ENABLE_BIT];
      ctrl_d.auto_reload = wdata[CTRL_AUTO_RELOAD_BIT];
      ctrl_d.irq_en      = wdata[CTRL_IRQ_EN_BIT];
    end
    ctrl_d.pending = match | (ctrl.pending & ~(wr_ctrl & wdata[CTRL_PENDING_BIT]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      cmp   <= '1;
      ctrl  <= '0;
    end else begin
      count <= count_d;
      cmp   <= cmp_d;
      ctrl  <= ctrl_d;
    end
  end

  assign irq_c = ctrl.pending & ctrl.irq_en;

endmodule
`endif

// File: rtl/dmem_mmio_subsystem.sv
// Data-side memory subsystem: word RAM plus GPIO/timer MMIO block behind the core MEM stage.
// Timer registers and timer_irq exist only when DMEM_MMIO_TIMER_EN is defined.
module dmem_mmio_subsystem
  import dmem_mmio_pkg::*;
#(
  parameter int unsigned RAM_DEPTH = 1024,
  parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
  parameter int unsigned GPIO_W    = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [DATA_W-1:0] daddr,
  input  logic [DATA_W-1:0] ddata_w,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic [DATA_W-1:0] ddata_r,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq,
  output logic              bus_err
);

  localparam int unsigned AW = $clog2(RAM_DEPTH);

  logic [DATA_W-1:0] ram [RAM_DEPTH];
  logic [DATA_W-1:0] ram_off;
  logic [AW-1:0]     ram_idx;
  logic [OFS_W-1:0]  mmio_ofs;
  logic              ram_hit;
  logic              mmio_hit;
  region_e           region;
  logic              mmio_wr;
  logic              bus_err_set;
  logic              bus_err_clr;
  logic [GPIO_W-1:0] gpio_s1;
  logic [GPIO_W-1:0] gpio_s2;
  logic [DATA_W-1:0] tmr_count;
  logic [DATA_W-1:0] tmr_cmp;
  logic [DATA_W-1:0] tmr_ctrl;

  // Offset compare keeps the RAM window check free of constant comparisons.
  assign ram_off  = daddr - RAM_BASE;
  assign ram_hit  = (ram_off >> (AW + 2)) == '0;
  assign mmio_hit = daddr[31:6] == MMIO_BASE[31:6];
  assign ram_idx  = daddr[AW+1:2];
  assign mmio_ofs = daddr[5:2];

  always_comb begin
    region = REG_NONE;
    if (ram_hit) begin
      region = REG_RAM;
    end else if (mmio_hit) begin
      region = REG_MMIO;
    end
  end

  assign mmio_wr     = MemWrite && (region == REG_MMIO);
  assign bus_err_set = (MemRead || MemWrite) && ((daddr[1:0] != 2'b00) || (region == REG_NONE));
  assign bus_err_clr = mmio_wr && (mmio_ofs == OFS_BUS_ERR) && ddata_w[0];

  always_ff @(posedge CLK) begin
    if (MemWrite && (region == REG_RAM)) begin
      ram[ram_idx] <= ddata_w;
    end
  end

  // Sticky error flag: a new error outranks a same-cycle clear.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bus_err  <= 1'b0;
      gpio_out <= '0;
      gpio_s1  <= '0;
      gpio_s2  <= '0;
    end else begin
      bus_err <= bus_err_set | (bus_err & ~bus_err_clr);
      gpio_s1 <= gpio_in;
      gpio_s2 <= gpio_s1;
      if (mmio_wr && (mmio_ofs == OFS_GPIO_OUT)) begin
        gpio_out <= ddata_w[GPIO_W-1:0];
      end
    end
  end

`ifdef DMEM_MMIO_TIMER_EN
  timer_ctrl_t tmr_ctrl_s;
  logic        tmr_wr_count;
  logic        tmr_wr_cmp;
  logic        tmr_wr_ctrl;

  assign tmr_wr_count = mmio_wr && (mmio_ofs == OFS_TIMER_COUNT);
  assign tmr_wr_cmp   = mmio_wr && (mmio_ofs == OFS_TIMER_CMP);
  assign tmr_wr_ctrl  = mmio_wr && (mmio_ofs == OFS_TIMER_CTRL);

  mmio_timer u_timer (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .wr_count (tmr_wr_count),
    .wr_cmp   (tmr_wr_cmp),
    .wr_ctrl  (tmr_wr_ctrl),
    .wdata    (ddata_w),
    .count    (tmr_count),
    .cmp      (tmr_cmp),
    .ctrl     (tmr_ctrl_s),
    .irq_c    (timer_irq)
  );

  assign tmr_ctrl = DATA_W'(tmr_ctrl_s);
`else
  assign tmr_count = '0;
  assign tmr_cmp   = '0;
  assign tmr_ctrl  = '0;
  assign timer_irq = 1'b0;
`endif

  // Combinational load path; a same-cycle store is seen only on later reads.
  always_comb begin
    ddata_r = '0;
    if (MemRead) begin
      case (region)
        REG_RAM: ddata_r = ram[ram_idx];
        REG_MMIO: begin
          case (mmio_ofs)
            OFS_GPIO_OUT:    ddata_r = DATA_W'(gpio_out);
            OFS_GPIO_IN:     ddata_r = DATA_W'(gpio_s2);
            OFS_TIMER_COUNT: ddata_r = tmr_count;
            OFS_TIMER_CMP:   ddata_r = tmr_cmp;
            OFS_TIMER_CTRL:  ddata_r = tmr_ctrl;
            OFS_BUS_ERR:     ddata_r = DATA_W'(bus_err);
            default:         ddata_r = '0;
          endcase
        end
        default: ddata_r = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio_subsystem.sv
// Scoreboard bench for dmem_mmio_subsystem; timer checks run when DMEM_MMIO_TIMER_EN is defined.
module tb_dmem_mmio_subsystem;

  localparam logic [31:0] MB = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] ddata_w = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] ddata_r;
  logic [7:0]  gpio_in = '0;
  logic [7:0]  gpio_out;
  logic        timer_irq;
  logic        bus_err;

  dmem_mmio_subsystem dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .daddr     (daddr),
    .ddata_w   (ddata_w),
    .MemRead   (mem_read),
    .MemWrite  (mem_write),
    .ddata_r   (ddata_r),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] probe(int sel);
    case (sel)
      0: return ddata_r;
      1: return 32'(bus_err);
      2: return 32'(gpio_out);
      default: return 32'(timer_irq);
    endcase
  endfunction

  // Monitor: compare every expectation queued for the current cycle at the falling edge.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      act = probe(e.sel);
      checks++;
      if (e.cyc != cyc || act !== e.val) begin
        errors++;
        $display("FAIL %s cyc=%0d got=%h want=%h", e.nm, cyc, act, e.val);
      end
    end
  end

  task automatic exp_push(input string nm, input int sel, input logic [31:0] v);
    q.push_back('{cyc, sel, v, nm});
  endtask

  task automatic bus(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    mem_read  = rd;
    mem_write = wr;
    daddr     = a;
    ddata_w   = d;
  endtask

  task automatic check_now(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values while reset is held
    repeat (2) @(posedge clk);
    #1;
    exp_push("rst_gpio_out", 2, 32'h0);
    exp_push("rst_bus_err", 1, 32'h0);
    exp_push("rst_irq", 3, 32'h0);
    bus(0, 0, 0, 0);
    rst_n = 1'b1;

    // RAM write/read
    bus(0, 1, 32'h10, 32'hDEAD_BEEF);
    bus(0, 1, 32'h14, 32'h1234_5678);
    bus(1, 0, 32'h10, 0); exp_push("ram_rd_10", 0, 32'hDEAD_BEEF);
    bus(1, 0, 32'h14, 0); exp_push("ram_rd_14", 0, 32'h1234_5678);
    exp_push("no_err", 1, 32'h0);

    // Unmapped read, sticky error, W1C clear
    bus(1, 0, 32'h4000_0000, 0); exp_push("unmapped_rd", 0, 32'h0); exp_push("err_not_yet", 1, 32'h0);
    bus(1, 0, MB + 32'h14, 0);   exp_push("err_reg_rd", 0, 32'h1); exp_push("err_set", 1, 32'h1);
    bus(0, 1, MB + 32'h14, 1);
    bus(0, 0, 0, 0);             exp_push("err_cleared", 1, 32'h0);

    // Misaligned read proceeds with low bits ignored and flags an error
    bus(1, 0, 32'h12, 0);        exp_push("misalign_rd", 0, 32'hDEAD_BEEF);
    bus(0, 0, 0, 0);             exp_push("misalign_err", 1, 32'h1);
    bus(0, 1, MB + 32'h14, 1);
    bus(0, 0, 0, 0);             exp_push("err_clr2", 1, 32'h0);

    // Misaligned W1C to BUS_ERR: the new error wins over the clear
    bus(0, 1, MB + 32'h15, 1);
    bus(0, 0, 0, 0);             exp_push("set_beats_clr", 1, 32'h1);
    bus(0, 1, MB + 32'h14, 1);

    // Write just past the RAM window is dropped (would alias index 0)
    bus(0, 1, 32'h0, 32'hCAFE_F00D);
    bus(0, 1, 32'h1000, 32'h0BAD_0BAD);
    bus(1, 0, 32'h0, 0);         exp_push("ram_end_drop", 0, 32'hCAFE_F00D); exp_push("ram_end_err", 1, 32'h1);
    bus(0, 1, MB + 32'h14, 1);

    // Reserved MMIO offsets: read 0, no error
    bus(0, 1, MB + 32'h18, 32'hFFFF_FFFF);
    bus(1, 0, MB + 32'h3C, 0);   exp_push("rsvd_rd", 0, 32'h0); exp_push("rsvd_no_err", 1, 32'h0);

    // GPIO input synchroniser and output register
    bus(1, 0, MB + 32'h4, 0); gpio_in = 8'hA5; exp_push("gpio_in_0", 0, 32'h0);
    bus(1, 0, MB + 32'h4, 0);    exp_push("gpio_in_1", 0, 32'h0);
    bus(1, 0, MB + 32'h4, 0);    exp_push("gpio_in_2", 0, 32'h0000_00A5);
    bus(0, 1, MB + 32'h0, 32'h1FF);
    bus(1, 0, MB + 32'h0, 0);    exp_push("gpio_out_rd", 0, 32'hFF); exp_push("gpio_out_pin", 2, 32'hFF);

    // Read-before-write on a simultaneous load/store
    bus(0, 1, 32'h20, 32'h1);
    bus(1, 1, 32'h20, 32'h2);    exp_push("rbw_old", 0, 32'h1);
    bus(1, 0, 32'h20, 0);        exp_push("rbw_new", 0, 32'h2);

`ifdef DMEM_MMIO_TIMER_EN
    // Timer: cmp=5 with auto-reload; pending rises after the match cycle
    bus(0, 1, MB + 32'hC, 5);
    bus(0, 1, MB + 32'h10, 32'h7);
    for (int i = 0; i < 6; i++) begin
      bus(1, 0, MB + 32'h8, 0);
      exp_push($sformatf("tmr_cnt_%0d", i), 0, 32'(i));
      exp_push($sformatf("tmr_irq_lo_%0d", i), 3, 32'h0);
    end
    bus(1, 0, MB + 32'h8, 0);    exp_push("tmr_reload", 0, 32'h0); exp_push("tmr_irq_hi", 3, 32'h1);
    bus(1, 0, MB + 32'h10, 0);   exp_push("tmr_ctrl_rd", 0, 32'hF);
    bus(0, 1, MB + 32'h10, 32'hF);
    bus(1, 0, MB + 32'h8, 0);    exp_push("tmr_after_w1c", 0, 32'h3); exp_push("tmr_irq_clr", 3, 32'h0);

    // COUNT write overrides increment; increment wraps at all-ones
    bus(0, 1, MB + 32'h8, 100);
    bus(1, 0, MB + 32'h8, 0);    exp_push("tmr_load", 0, 32'd100);
    bus(1, 0, MB + 32'h8, 0);    exp_push("tmr_inc", 0, 32'd101);
    bus(0, 1, MB + 32'h8, 32'hFFFF_FFFF);
    bus(1, 0, MB + 32'h8, 0);    exp_push("tmr_max", 0, 32'hFFFF_FFFF);
    bus(1, 0, MB + 32'h8, 0);    exp_push("tmr_wrap", 0, 32'h0);

    // Set bus_err, then run timer to count=3 with pending before async reset
    bus(1, 0, 32'h4000_0000, 0);
    bus(0, 1, MB + 32'h10, 0);
    bus(0, 1, MB + 32'hC, 2);
    bus(0, 1, MB + 32'h8, 0);
    bus(0, 1, MB + 32'h10, 32'h5);
    for (int i = 0; i < 3; i++) begin
      bus(1, 0, MB + 32'h8, 0);
      exp_push($sformatf("tmr2_cnt_%0d", i), 0, 32'(i));
    end
    bus(1, 0, MB + 32'h8, 0);    exp_push("tmr2_cnt_3", 0, 32'h3); exp_push("tmr2_irq", 3, 32'h1);
`else
    // Timer offsets absent: read 0, writes ignored
    bus(0, 1, MB + 32'h8, 32'h55);
    bus(0, 1, MB + 32'hC, 32'h55);
    bus(0, 1, MB + 32'h10, 32'hF);
    bus(1, 0, MB + 32'h8, 0);    exp_push("no_tmr_cnt", 0, 32'h0);
    bus(1, 0, MB + 32'hC, 0);    exp_push("no_tmr_cmp", 0, 32'h0);
    bus(1, 0, MB + 32'h10, 0);   exp_push("no_tmr_ctrl", 0, 32'h0); exp_push("no_tmr_irq", 3, 32'h0);
    bus(1, 0, 32'h4000_0000, 0);
    bus(1, 0, MB + 32'h8, 0);    exp_push("pre_rst_err", 1, 32'h1);
`endif

    // Async reset mid-cycle, observed before any further rising edge
    @(negedge clk);
    #1;
    exp_push("pre_rst_gpio", 2, 32'hFF);
    if (gpio_out !== 8'hFF) begin
      q.delete();
    end
    rst_n = 1'b0;
    #1;
    check_now("async_gpio_out", 32'(gpio_out), 32'h0);
    check_now("async_bus_err", 32'(bus_err), 32'h0);
    check_now("async_irq", 32'(timer_irq), 32'h0);
    check_now("async_ddata_r", ddata_r, 32'h0);
    q.delete();

    bus(0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (2) bus(0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_now("queue_drained", 32'(q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_subsystem.md
Name: dmem_mmio_subsystem

Overview:
Data-side memory subsystem that sits directly downstream of the RV32I core's MEM stage.
- Consumes the core's daddr/ddata_w/MemRead/MemWrite and returns ddata_r.
- Decodes the address into a word-addressed data RAM and a small MMIO register block.
- The MMIO block holds a GPIO output register, a synchronised GPIO input, and a 32-bit timer with compare interrupt.
- Single-cycle MEM stage: reads are combinational, writes commit on the clock edge.

Parameters:
RAM_DEPTH, 1024, number of 32-bit RAM words (power of 2)
RAM_BASE, 32'h0000_0000, byte base address of RAM
MMIO_BASE, 32'h8000_0000, byte base address of MMIO window (64 bytes)
GPIO_W, 8, width of gpio_out/gpio_in

Ports:
CLK  input  1  system clock; all state updates on rising edge
RESET_N  input  1  reset, asynchronous, active-low
daddr  input  32  byte address from core MEM stage
ddata_w  input  32  store data from core
MemRead  input  1  load strobe
MemWrite  input  1  store strobe
ddata_r  output  32  load data to core (combinational)
gpio_in  input  GPIO_W  asynchronous external inputs
gpio_out  output  GPIO_W  registered GPIO output
timer_irq  output  1  level interrupt = pending & irq_en
bus_err  output  1  sticky flag: unmapped or misaligned access seen

Behaviour:
- Reset (RESET_N low, asynchronous): gpio_out=0, timer count=0, compare=32'hFFFF_FFFF, ctrl=0, pending=0, bus_err=0, gpio sync flops=0. RAM contents are not reset.
- Decode:
  - RAM hit when daddr in [RAM_BASE, RAM_BASE+4*RAM_DEPTH).
  - RAM index = daddr[$clog2(RAM_DEPTH)+1:2].
  - MMIO hit when daddr[31:6]==MMIO_BASE[31:6]; offset = daddr[5:2].
- Word accesses only. daddr[1:0]!=0 with MemRead|MemWrite sets bus_err. The access proceeds with bits [1:0] ignored.
- Read, 0-cycle latency: ddata_r valid in the same cycle as MemRead.
  - RAM hit -> RAM word.
  - MMIO hit -> register value.
  - Unmapped -> 0, and bus_err set at the next edge.
  - MemRead=0 -> ddata_r=0.
- Write: commits at the rising edge with MemWrite=1. Unmapped writes are dropped and set bus_err.
- MemRead and MemWrite both high: the write commits. ddata_r returns the pre-write value (read-before-write).
- MMIO map (offset words):
  - 0 GPIO_OUT: RW, low GPIO_W bits.
  - 1 GPIO_IN: RO, 2-flop synchronised, zero-extended.
  - 2 TIMER_COUNT: RW.
  - 3 TIMER_CMP: RW.
  - 4 TIMER_CTRL: bit0 enable, bit1 auto_reload, bit2 irq_en, bit3 pending (W1C), others read 0.
  - 5 BUS_ERR: bit0 = bus_err, W1C.
  - 6-15: read 0, writes ignored, no bus_err.
- Timer state per cycle, in priority order:
  1. Software write to COUNT: that value is loaded, no increment.
  2. Else if enable, count == cmp, and auto_reload: count becomes 0.
  3. Else if enable: count increments by 1, wrapping 32'hFFFF_FFFF to 0.
- Pending: set when enable and count==cmp, evaluated on the pre-update count.
- Set beats W1C clear in the same cycle.
- Writing ctrl with enable=0 freezes count; pending is held.
- timer_irq = pending & irq_en, combinational from registers.
- bus_err set and W1C clear in the same cycle: set wins.

Optional Feature:
DMEM_MMIO_TIMER_EN
- Defined: timer, TIMER_* registers and timer_irq are present as described.
- Undefined: no timer logic is instantiated. Offsets 2-4 read 0 and ignore writes. timer_irq is tied 0. GPIO and RAM are unaffected.

Decomposition:
- Package dmem_mmio_pkg:
  - MMIO offset localparams (OFS_GPIO_OUT..OFS_BUS_ERR).
  - CTRL bit-index constants.
  - Typedef timer_ctrl_t: packed struct {enable, auto_reload, irq_en, pending}.
  - Typedef region_e: enum {REG_RAM, REG_MMIO, REG_NONE}.
- Sub-module mmio_timer: count/cmp/ctrl registers, match and pending logic, irq output. Instantiated under DMEM_MMIO_TIMER_EN.

Test Plan:
1. Reset, then write 32'hDEADBEEF to 0x0000_0010, then read 0x0000_0010 -> ddata_r=32'hDEADBEEF in the read cycle. Reading 0x0000_0014 returns a different, independently written word.
2. Read 0x4000_0000 -> ddata_r=0, bus_err=1 next cycle. Read of MMIO offset 5 -> 32'h1. Write 1 to offset 5 -> bus_err=0.
3. Drive gpio_in=8'hA5 -> GPIO_IN reads 32'h0000_00A5 no earlier than the 2nd edge. Write GPIO_OUT 32'h1FF -> gpio_out=8'hFF.
4. Timer: cmp=5, ctrl=enable|auto_reload|irq_en -> count sequence 0..5,0. pending and timer_irq rise the cycle after count==5. W1C of pending in a non-match cycle clears timer_irq.
5. Simultaneous MemRead+MemWrite to RAM word holding 32'h1 with ddata_w=32'h2 -> ddata_r=32'h1 that cycle, 32'h2 on the next read.
6. Assert RESET_N low mid-count (count=3, pending=1) -> count=0, pending=0, gpio_out=0, timer_irq=0 immediately, without waiting for a clock edge.
